// File: rtl/std_cache_pkg.sv
// rtl/std_cache_pkg.sv - shared L1 data cache types: MSHR entry state and entry record
package std_cache_pkg;

  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_BYTE_OFFSET = 4;
  localparam int unsigned MSHR_ADDR_WIDTH    = 56;
  localparam int unsigned MSHR_NR_PORTS      = 3;

  typedef enum logic [1:0] {
    MSHR_IDLE     = 2'd0,
    MSHR_PENDING  = 2'd1,
    MSHR_INFLIGHT = 2'd2
  } mshr_state_e;

  typedef struct packed {
    logic [MSHR_ADDR_WIDTH-1:0] addr;
    logic [MSHR_NR_PORTS-1:0]   port_mask;
    mshr_state_e                state;
  } mshr_entry_t;

endpackage

// File: rtl/rr_arb_tree.sv
// rtl/rr_arb_tree.sv - round-robin one-hot arbiter, priority rotates past the last winner
module rr_arb_tree #(
  parameter int unsigned NUM_IN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req,
  output logic [NUM_IN-1:0] gnt
);

  localparam int unsigned IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic             found;

  // Search from the pointer upward, wrapping, for the first requester
  always_comb begin
    gnt   = '0;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (!found && req[(int'(ptr) + k) % NUM_IN]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(ptr) + k) % NUM_IN);
      end
    end
    if (found) gnt[idx] = 1'b1;
  end

  // Move priority to the port after the winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (idx == IDX_W'(NUM_IN - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/std_mshr_file.sv
// rtl/std_mshr_file.sv - MSHR file for the non-blocking L1 D$; optional merging via STD_MSHR_MERGE_EN
module std_mshr_file
  import std_cache_pkg::*;
#(
  parameter int unsigned NR_PORTS    = MSHR_NR_PORTS,
  parameter int unsigned NR_MSHR     = 4,
  parameter int unsigned ADDR_WIDTH  = MSHR_ADDR_WIDTH,
  parameter int unsigned INDEX_WIDTH = DCACHE_INDEX_WIDTH,
  parameter int unsigned BYTE_OFFSET = DCACHE_BYTE_OFFSET,
  parameter int unsigned ID_WIDTH    = $clog2(NR_MSHR)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic [NR_PORTS-1:0]            alloc_req_i,
  input  logic [NR_PORTS*ADDR_WIDTH-1:0] alloc_addr_i,
  output logic [NR_PORTS-1:0]            alloc_gnt_o,
  output logic [ID_WIDTH-1:0]            alloc_id_o,
  input  logic [NR_PORTS*ADDR_WIDTH-1:0] lookup_addr_i,
  output logic [NR_PORTS-1:0]            addr_match_o,
  output logic [NR_PORTS-1:0]            index_match_o,
  output logic                           refill_req_o,
  output logic [ADDR_WIDTH-1:0]          refill_addr_o,
  output logic [ID_WIDTH-1:0]            refill_id_o,
  input  logic                           refill_gnt_i,
  input  logic                           done_valid_i,
  input  logic [ID_WIDTH-1:0]            done_id_i,
  output logic [NR_PORTS-1:0]            resp_valid_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic                           busy_o
);

  localparam int unsigned TAG_W = ADDR_WIDTH - BYTE_OFFSET;
  localparam int unsigned IDX_W = INDEX_WIDTH - BYTE_OFFSET;

  mshr_entry_t         entries [NR_MSHR];
  logic [ID_WIDTH-1:0] fifo_id [NR_MSHR];
  logic [ID_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ID_WIDTH:0]   fifo_cnt;

  logic [NR_MSHR-1:0]    live;
  logic                  done_fire;
  logic [NR_PORTS-1:0]   hit, hit_freeing, eligible, gnt;
  logic [ID_WIDTH-1:0]   hit_id [NR_PORTS];
  logic [ID_WIDTH-1:0]   free_id, gnt_hit_id;
  logic [ADDR_WIDTH-1:0] gnt_line;
  logic                  gnt_hit, merge_grant, new_alloc, issue;

  // Entry liveness and whether this cycle's completion is a real one
  always_comb begin
    for (int i = 0; i < NR_MSHR; i++) live[i] = (entries[i].state != MSHR_IDLE);
    done_fire = done_valid_i && (entries[done_id_i].state == MSHR_INFLIGHT);
  end

  // Hazard lookups and allocation-address hits against live entries
  always_comb begin
    addr_match_o  = '0;
    index_match_o = '0;
    hit           = '0;
    hit_freeing   = '0;
    for (int p = 0; p < NR_PORTS; p++) hit_id[p] = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      for (int i = 0; i < NR_MSHR; i++) begin
        if (live[i]) begin
          if (entries[i].addr[ADDR_WIDTH-1:BYTE_OFFSET] == lookup_addr_i[p*ADDR_WIDTH+BYTE_OFFSET +: TAG_W])
            addr_match_o[p] = 1'b1;
          if (entries[i].addr[INDEX_WIDTH-1:BYTE_OFFSET] == lookup_addr_i[p*ADDR_WIDTH+BYTE_OFFSET +: IDX_W])
            index_match_o[p] = 1'b1;
          if (entries[i].addr[ADDR_WIDTH-1:BYTE_OFFSET] == alloc_addr_i[p*ADDR_WIDTH+BYTE_OFFSET +: TAG_W]) begin
            hit[p]    = 1'b1;
            hit_id[p] = ID_WIDTH'(i);
            if (done_fire && done_id_i == ID_WIDTH'(i)) hit_freeing[p] = 1'b1;
          end
        end
      end
    end
  end

  // Occupancy flags and the lowest-index free entry
  always_comb begin
    full_o  = &live;
    empty_o = ~|live;
    busy_o  = |live;
    free_id = '0;
    for (int i = NR_MSHR - 1; i >= 0; i--) if (!live[i]) free_id = ID_WIDTH'(i);
  end

  // Which ports may compete this cycle; a hit on a freeing entry waits for the free
  always_comb begin
    eligible = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
`ifdef STD_MSHR_MERGE_EN
      eligible[p] = alloc_req_i[p] && !flush_i && (hit[p] ? !hit_freeing[p] : !full_o);
`else
      eligible[p] = alloc_req_i[p] && !flush_i && !hit[p] && !full_o;
`endif
    end
  end

  rr_arb_tree #(.NUM_IN(NR_PORTS)) i_port_arb (
    .clk (clk_i),
    .rst (rst_i),
    .req (eligible),
    .gnt (gnt)
  );

  // Decode the winning port; without merging a granted port never hits
  always_comb begin
    gnt_line   = '0;
    gnt_hit    = 1'b0;
    gnt_hit_id = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      if (gnt[p]) begin
        gnt_line   = {alloc_addr_i[p*ADDR_WIDTH+BYTE_OFFSET +: TAG_W], BYTE_OFFSET'(0)};
        gnt_hit    = hit[p];
        gnt_hit_id = hit_id[p];
      end
    end
    merge_grant  = (|gnt) && gnt_hit && !(|hit_freeing & 1'b0);
    new_alloc    = (|gnt) && !gnt_hit;
    alloc_gnt_o  = gnt;
    alloc_id_o   = gnt_hit ? gnt_hit_id : free_id;
    refill_req_o = (fifo_cnt != '0);
    refill_id_o  = fifo_id[rd_ptr];
    refill_addr_o = entries[refill_id_o].addr[ADDR_WIDTH-1:0];
    issue        = refill_req_o && refill_gnt_i;
  end

  // Per-entry state machine: allocate/merge, issue, complete
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_MSHR; i++) entries[i] <= '{addr: '0, port_mask: '0, state: MSHR_IDLE};
    end else begin
      for (int i = 0; i < NR_MSHR; i++) begin
        if (new_alloc && free_id == ID_WIDTH'(i)) begin
          entries[i].addr      <= MSHR_ADDR_WIDTH'(gnt_line);
          entries[i].port_mask <= MSHR_NR_PORTS'(gnt);
          entries[i].state     <= MSHR_PENDING;
        end else if (merge_grant && gnt_hit_id == ID_WIDTH'(i)) begin
          entries[i].port_mask <= entries[i].port_mask | MSHR_NR_PORTS'(gnt);
        end
        if (issue && refill_id_o == ID_WIDTH'(i)) entries[i].state <= MSHR_INFLIGHT;
        if (done_fire && done_id_i == ID_WIDTH'(i)) entries[i].state <= MSHR_IDLE;
      end
    end
  end

  // In-order issue FIFO of entry ids plus the completion wake-up pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_MSHR; i++) fifo_id[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      resp_valid_o <= '0;
    end else begin
      if (new_alloc) begin
        fifo_id[wr_ptr] <= free_id;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({new_alloc, issue})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      resp_valid_o <= done_fire ? entries[done_id_i].port_mask[NR_PORTS-1:0] : '0;
    end
  end

  // Completions must name an entry that is actually in flight
  a_done_inflight: assert property (@(posedge clk_i) disable iff (rst_i)
    done_valid_i |-> entries[done_id_i].state == MSHR_INFLIGHT)
    else $error("std_mshr_file: completion on non-inflight id %0d", done_id_i);

endmodule

// File: tb/tb_std_mshr_file.sv
// tb/tb_std_mshr_file.sv - scoreboard bench for std_mshr_file
module tb_std_mshr_file;

  localparam int NP = 3;
  localparam int AW = 56;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic [NP-1:0]     alloc_req = '0;
  logic [NP*AW-1:0]  alloc_addr = '0;
  logic [NP-1:0]     alloc_gnt;
  logic [IW-1:0]     alloc_id;
  logic [NP*AW-1:0]  lookup_addr = '0;
  logic [NP-1:0]     addr_match, index_match;
  logic              refill_req;
  logic [AW-1:0]     refill_addr;
  logic [IW-1:0]     refill_id;
  logic              refill_gnt = 1'b0;
  logic              done_valid = 1'b0;
  logic [IW-1:0]     done_id = '0;
  logic [NP-1:0]     resp_valid;
  logic              full, empty, busy;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned   exp_id_q[$];
  logic [AW-1:0] exp_addr_q[$];

  std_mshr_file dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .alloc_req_i(alloc_req), .alloc_addr_i(alloc_addr),
    .alloc_gnt_o(alloc_gnt), .alloc_id_o(alloc_id),
    .lookup_addr_i(lookup_addr), .addr_match_o(addr_match), .index_match_o(index_match),
    .refill_req_o(refill_req), .refill_addr_o(refill_addr), .refill_id_o(refill_id),
    .refill_gnt_i(refill_gnt), .done_valid_i(done_valid), .done_id_i(done_id),
    .resp_valid_o(resp_valid), .full_o(full), .empty_o(empty), .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic on, input logic [AW-1:0] a);
    alloc_req[p] = on;
    alloc_addr[p*AW +: AW] = a;
  endtask

  task automatic expect_issue(input int unsigned id, input logic [AW-1:0] a);
    exp_id_q.push_back(id);
    exp_addr_q.push_back(a);
  endtask

  task automatic issue_one;
    int unsigned   eid;
    logic [AW-1:0] ea;
    check("refill_req", refill_req, 1);
    check("issue_sb_nonempty", exp_id_q.size() != 0, 1);
    if (exp_id_q.size() != 0) begin
      eid = exp_id_q.pop_front();
      ea  = exp_addr_q.pop_front();
      check("refill_id", refill_id, eid);
      check("refill_addr", refill_addr, ea);
    end
    refill_gnt = 1'b1;
    tick;
    refill_gnt = 1'b0;
  endtask

  task automatic finish_one(input int id, input logic [NP-1:0] mask);
    done_valid = 1'b1;
    done_id    = IW'(id);
    tick;
    done_valid = 1'b0;
    check("resp_valid", resp_valid, mask);
  endtask

  initial begin
    logic [AW-1:0] lines [4];
    lines[0] = 56'h1000; lines[1] = 56'h2000; lines[2] = 56'h3000; lines[3] = 56'h4000;

    tick; tick;
    check("rst_gnt", alloc_gnt, 0);
    check("rst_refill_req", refill_req, 0);
    check("rst_resp", resp_valid, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick;

    // single miss from port 1, lookup hazards, completion
    set_req(1, 1'b1, 56'h8000_0040);
    #1;
    check("p1_gnt", alloc_gnt, 3'b010);
    check("p1_id", alloc_id, 0);
    expect_issue(0, 56'h8000_0040);
    tick;
    set_req(1, 1'b0, '0);
    check("p1_busy", busy, 1);
    issue_one;
    lookup_addr[0*AW +: AW] = 56'h8000_0048;
    lookup_addr[2*AW +: AW] = 56'h9000_0040;
    #1;
    check("lookup_addr_hit", addr_match[0], 1);
    check("lookup_index_hit", index_match[2], 1);
    check("lookup_addr_miss", addr_match[2], 0);
    finish_one(0, 3'b010);
    check("p1_empty", empty, 1);
    tick;
    check("resp_one_cycle", resp_valid, 0);

    // fill the file with distinct lines
    for (int k = 0; k < 4; k++) begin
      set_req(k % 3, 1'b1, lines[k]);
      #1;
      check("fill_gnt", alloc_gnt, 64'd1 << (k % 3));
      check("fill_id", alloc_id, k);
      expect_issue(k, lines[k]);
      tick;
      set_req(k % 3, 1'b0, '0);
    end
    check("full", full, 1);
    set_req(0, 1'b1, 56'h5000);
    #1;
    check("full_no_gnt", alloc_gnt, 0);
    for (int k = 0; k < 4; k++) issue_one;
    done_valid = 1'b1;
    done_id    = 2'd2;
    #1;
    check("full_done_same_cycle", alloc_gnt, 0);
    tick;
    done_valid = 1'b0;
    #1;
    check("freed_resp", resp_valid, 3'b100);
    check("freed_gnt", alloc_gnt, 3'b001);
    check("freed_id", alloc_id, 2);
    expect_issue(2, 56'h5000);
    tick;
    set_req(0, 1'b0, '0);
    issue_one;
    finish_one(0, 3'b001);
    finish_one(1, 3'b010);
    finish_one(3, 3'b001);
    finish_one(2, 3'b001);
    check("drain_empty", empty, 1);

    // flush blocks grants
    flush = 1'b1;
    set_req(2, 1'b1, 56'h6000);
    #1;
    check("flush_gnt0", alloc_gnt, 0);
    tick;
    check("flush_gnt1", alloc_gnt, 0);
    flush = 1'b0;
    #1;
    check("post_flush_gnt", alloc_gnt, 3'b100);
    check("post_flush_id", alloc_id, 0);
    expect_issue(0, 56'h6000);
    tick;
    set_req(2, 1'b0, '0);
    issue_one;
    finish_one(0, 3'b100);

    // two ports on the same line
    set_req(0, 1'b1, 56'h100);
    set_req(1, 1'b1, 56'h100);
    #1;
    check("same_gnt0", alloc_gnt, 3'b001);
    check("same_id0", alloc_id, 0);
    expect_issue(0, 56'h100);
    tick;
    set_req(0, 1'b0, '0);
    #1;
`ifdef STD_MSHR_MERGE_EN
    check("merge_gnt", alloc_gnt, 3'b010);
    check("merge_id", alloc_id, 0);
    tick;
    set_req(1, 1'b0, '0);
    issue_one;
    #1;
    check("merge_single_issue", refill_req, 0);
    finish_one(0, 3'b011);
`else
    check("stall_gnt", alloc_gnt, 0);
    issue_one;
    done_valid = 1'b1;
    done_id    = 2'd0;
    #1;
    check("stall_in_done", alloc_gnt, 0);
    tick;
    done_valid = 1'b0;
    #1;
    check("stall_resp", resp_valid, 3'b001);
    check("stall_release_gnt", alloc_gnt, 3'b010);
    check("stall_release_id", alloc_id, 0);
    expect_issue(0, 56'h100);
    tick;
    set_req(1, 1'b0, '0);
    issue_one;
    finish_one(0, 3'b010);
`endif

    // asynchronous reset with two entries in flight
    set_req(0, 1'b1, 56'hA000);
    #1;
    check("pre_rst_id0", alloc_id, 0);
    expect_issue(0, 56'hA000);
    tick;
    set_req(0, 1'b0, '0);
    set_req(1, 1'b1, 56'hB000);
    #1;
    check("pre_rst_id1", alloc_id, 1);
    expect_issue(1, 56'hB000);
    tick;
    set_req(1, 1'b0, '0);
    issue_one;
    issue_one;
    check("pre_rst_busy", busy, 1);
    lookup_addr[0*AW +: AW] = 56'hA000;
    #2;
    rst = 1'b1;
    #1;
    check("arst_refill_req", refill_req, 0);
    check("arst_empty", empty, 1);
    check("arst_full", full, 0);
    check("arst_busy", busy, 0);
    check("arst_resp", resp_valid, 0);
    check("arst_addr_match", addr_match[0], 0);
    tick;
    rst = 1'b0;
    tick;
    check("post_rst_refill_req", refill_req, 0);
    check("issue_sb_drained", exp_id_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
